perf_cnt_bank: RTL



---
 rtl/perf_cnt_pkg.sv | 16 +
 rtl/perf_cnt_bank_if.sv | 10 +
 rtl/perf_cnt_bank_req_sync.sv | 25 ++
 rtl/perf_cnt_bank.sv | 127 ++++++++++++
 4 files changed

// File: rtl/perf_cnt_pkg.sv
// rtl/perf_cnt_pkg.sv - shared constants and FSM state type for the performance-counter bank
package perf_cnt_pkg;

    localparam logic [7:0]  OFF_CYC_LO   = 8'h00;
    localparam logic [7:0]  OFF_CYC_HI   = 8'h04;
    localparam logic [7:0]  OFF_EVT_BASE = 8'h08;
    localparam logic [7:0]  OFF_ID       = 8'hFC;
    localparam logic [31:0] ID_WORD_DEF  = 32'h4E53_4350;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        ACK
    } state_e;

endpackage

// File: rtl/perf_cnt_bank_if.sv
// rtl/perf_cnt_bank_if.sv - four-phase counter-read port between bridge (master) and bank (slave)
interface perf_cnt_bank_if;
    logic        cnt_req;
    logic [31:0] cnt_addr;
    logic [31:0] cnt_data;
    logic        cnt_ack;

    modport master (output cnt_req, output cnt_addr, input cnt_data, input cnt_ack);
    modport slave  (input cnt_req, input cnt_addr, output cnt_data, output cnt_ack);
endinterface

// File: rtl/perf_cnt_bank_req_sync.sv
// rtl/perf_cnt_bank_req_sync.sv - flop chain bringing the read request into the core clock domain
module cnt_req_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    if (STAGES == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_chain
        logic [STAGES-1:0] sync_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= STAGES'({sync_q, d_i});
            end
        end

        assign q_o = sync_q[STAGES-1];
    end
endmodule

// File: rtl/perf_cnt_bank.sv
// rtl/perf_cnt_bank.sv - cycle and event counters read as tear-free 32-bit halves over a req/ack port
module perf_cnt_bank
    import perf_cnt_pkg::*;
#(
    parameter int          NUM_EVT     = 4,
    parameter int          CNT_W       = 64,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_WORD     = ID_WORD_DEF
) (
    input  logic               coreclk,
    input  logic               corerstn,
    input  logic               cnt_en,
    input  logic               cnt_clr,
    input  logic [NUM_EVT-1:0] evt_i,
    perf_cnt_bank_if.slave     bus
);
    localparam int HI_W = CNT_W - 32;
    localparam int NCNT = NUM_EVT + 1;

    logic                          req_s;
    state_e                        state_q;
    logic [31:0]                   data_q;
    logic                          ack_q;
    logic [CNT_W-1:0]              cyc_q, cyc_d;
    logic [NUM_EVT-1:0][CNT_W-1:0] evt_q, evt_d;
    logic [NCNT-1:0][CNT_W-1:0]    all_q;
    logic [NCNT-1:0][HI_W-1:0]     shad_q, shad_d;
    logic [5:0]                    widx;
    logic [31:0]                   rd_word;
    logic                          unused_addr;

    cnt_req_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (coreclk),
        .rst_n (corerstn),
        .d_i   (bus.cnt_req),
        .q_o   (req_s)
    );

    assign widx        = bus.cnt_addr[7:2];
    assign unused_addr = ^{bus.cnt_addr[31:8], bus.cnt_addr[1:0]};
    // Counter k: 0 is the cycle counter, k>=1 is event counter k-1; word 2k is lo, 2k+1 is hi.
    assign all_q       = {evt_q, cyc_q};

    always_comb begin
        cyc_d = cyc_q;
        evt_d = evt_q;
        if (cnt_clr) begin
            cyc_d = '0;
            evt_d = '0;
        end else if (cnt_en) begin
            cyc_d = cyc_q + CNT_W'(1);
            for (int i = 0; i < NUM_EVT; i++) begin
                evt_d[i] = evt_q[i] + CNT_W'(evt_i[i]);
            end
        end
    end

    // A lo read latches the upper bits so the following hi read matches it even if the counter carries.
    always_comb begin
        rd_word = '0;
        shad_d  = shad_q;
        for (int k = 0; k < NCNT; k++) begin
            if (widx[5:1] == 5'(k)) begin
                rd_word = widx[0] ? 32'(shad_q[k]) : all_q[k][31:0];
                if (state_q == LOOKUP && !widx[0]) begin
                    shad_d[k] = all_q[k][CNT_W-1:32];
                end
            end
        end
        if (widx == OFF_ID[7:2]) begin
            rd_word = ID_WORD;
        end
        if (cnt_clr) begin
            shad_d = '0;
        end
    end

    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            cyc_q  <= '0;
            evt_q  <= '0;
            shad_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            evt_q  <= evt_d;
            shad_q <= shad_d;
        end
    end

    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            state_q <= IDLE;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    data_q  <= rd_word;
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_data = data_q;
    assign bus.cnt_ack  = ack_q;

    a_addr_stable: assert property (@(posedge coreclk) disable iff (!corerstn)
        bus.cnt_req && $past(bus.cnt_req) |-> $stable(bus.cnt_addr));

endmodule
